// File: rtl/sne_evt_stream_pkg.sv
// Event-stream package: opcode encoding, update-event constant, scheduler state type
// and the stream handshake helper macros shared by every stream block.
`ifndef SNE_EVT_STREAM_MACROS
`define SNE_EVT_STREAM_MACROS
`define SNE_EVT_STREAM_ASSIGN(out_s, in_s) \
  out_s.valid = in_s.valid; \
  out_s.evt   = in_s.evt; \
  in_s.ready  = out_s.ready;
`define SNE_EVT_STREAM_PAUSE(out_s, in_s) \
  out_s.valid = 1'b0; \
  out_s.evt   = in_s.evt; \
  in_s.ready  = 1'b0;
`endif

package sne_evt_stream_pkg;

  localparam int unsigned EVENT_WIDTH   = 32;
  localparam int unsigned OP_WIDTH      = 4;
  localparam int unsigned CATCHUP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] EVT_SPIKE  = 4'h1;
  localparam logic [OP_WIDTH-1:0] EVT_TIME   = 4'h2;
  localparam logic [OP_WIDTH-1:0] EVT_UPDATE = 4'h3;

  localparam logic [EVENT_WIDTH-1:0] UPDATE_EVENT =
    {EVT_UPDATE, {(EVENT_WIDTH-OP_WIDTH){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INSERT  = 2'd1,
    RELEASE = 2'd2
  } refresh_state_e;

  function automatic logic [OP_WIDTH-1:0] evt_op(input logic [EVENT_WIDTH-1:0] evt);
    return evt[EVENT_WIDTH-1 -: OP_WIDTH];
  endfunction

endpackage

// File: rtl/sne_event_stream_if.sv
// Valid/ready event stream carrying one opcode-tagged event word per handshake.
interface SNE_EVENT_STREAM;
  import sne_evt_stream_pkg::*;

  logic                   valid;
  logic                   ready;
  logic [EVENT_WIDTH-1:0] evt;

  modport src (output valid, output evt, input ready);
  modport dst (input valid, input evt, output ready);
endinterface

// File: rtl/evt_epoch_delta.sv
// Extracts the refresh epoch of a time event, detects an epoch crossing and
// returns how many update events to insert (capped, wrap counts as one).
module evt_epoch_delta
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned TS_WIDTH    = 28,
  parameter int unsigned MAX_CATCHUP = 4,
  parameter int unsigned SHIFT_WIDTH = $clog2(TS_WIDTH)
) (
  input  logic [OP_WIDTH-1:0]      op_i,
  input  logic [TS_WIDTH-1:0]      ts_i,
  input  logic [SHIFT_WIDTH-1:0]   shift_i,
  input  logic [TS_WIDTH-1:0]      last_epoch_i,
  output logic                     is_time_o,
  output logic [TS_WIDTH-1:0]      epoch_o,
  output logic                     crossing_o,
  output logic [CATCHUP_WIDTH-1:0] catchup_o
);

  logic [TS_WIDTH-1:0] delta;

  always_comb begin
    is_time_o  = (op_i == EVT_TIME);
    epoch_o    = ts_i >> shift_i;
    delta      = epoch_o - last_epoch_i;
    crossing_o = is_time_o && (epoch_o != last_epoch_i) && (epoch_o != '0);
    if (epoch_o > last_epoch_i) begin
      catchup_o = (delta > TS_WIDTH'(MAX_CATCHUP)) ? CATCHUP_WIDTH'(MAX_CATCHUP)
                                                   : delta[CATCHUP_WIDTH-1:0];
    end else begin
      // Epoch went backwards: the timestamp wrapped, treat as a single crossing.
      catchup_o = CATCHUP_WIDTH'(1);
    end
  end

endmodule

// File: rtl/evt_refresh_scheduler.sv
// Inserts UPDATE events ahead of a time event whenever its refresh epoch advances;
// otherwise a zero-latency pass-through of the event stream.
module evt_refresh_scheduler
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned TS_WIDTH    = 28,
  parameter int unsigned MAX_CATCHUP = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic [$clog2(TS_WIDTH)-1:0] refresh_shift_i,
  SNE_EVENT_STREAM.dst                evt_time_stream_dst,
  SNE_EVENT_STREAM.src                evt_time_stream_src,
  output logic [CNT_WIDTH-1:0]        refresh_count_o,
  output logic                        busy_o
);

  localparam int unsigned SHIFT_WIDTH = $clog2(TS_WIDTH);

  refresh_state_e             state_q, state_d;
  logic [TS_WIDTH-1:0]        last_epoch_q, last_epoch_d;
  logic [CATCHUP_WIDTH-1:0]   ins_cnt_q, ins_cnt_d;
  logic [CNT_WIDTH-1:0]       count_q, count_d;
  logic [SHIFT_WIDTH-1:0]     shift_q, shift_d;

  logic [SHIFT_WIDTH-1:0]     eff_shift;
  logic                       is_time;
  logic [TS_WIDTH-1:0]        epoch;
  logic                       crossing;
  logic [CATCHUP_WIDTH-1:0]   catchup;
  logic                       src_fire;

  // The shift is only sampled in IDLE; a burst keeps the value it started with.
  assign eff_shift = (state_q == IDLE) ? refresh_shift_i : shift_q;

  evt_epoch_delta #(
    .TS_WIDTH    (TS_WIDTH),
    .MAX_CATCHUP (MAX_CATCHUP),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_epoch_delta (
    .op_i         (evt_op(evt_time_stream_dst.evt)),
    .ts_i         (evt_time_stream_dst.evt[TS_WIDTH-1:0]),
    .shift_i      (eff_shift),
    .last_epoch_i (last_epoch_q),
    .is_time_o    (is_time),
    .epoch_o      (epoch),
    .crossing_o   (crossing),
    .catchup_o    (catchup)
  );

  always_comb begin
    state_d      = state_q;
    last_epoch_d = last_epoch_q;
    ins_cnt_d    = ins_cnt_q;
    count_d      = count_q;
    shift_d      = shift_q;
    src_fire     = 1'b0;
    `SNE_EVT_STREAM_ASSIGN(evt_time_stream_src, evt_time_stream_dst)

    case (state_q)
      IDLE: begin
        shift_d = refresh_shift_i;
        if (enable_i && evt_time_stream_dst.valid && crossing) begin
          `SNE_EVT_STREAM_PAUSE(evt_time_stream_src, evt_time_stream_dst)
          ins_cnt_d = catchup;
          state_d   = INSERT;
        end
      end
      INSERT: begin
        evt_time_stream_src.valid = 1'b1;
        evt_time_stream_src.evt   = UPDATE_EVENT;
        evt_time_stream_dst.ready = 1'b0;
        if (evt_time_stream_src.ready) begin
          ins_cnt_d = ins_cnt_q - CATCHUP_WIDTH'(1);
          if (count_q != '1) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
          if (ins_cnt_q == CATCHUP_WIDTH'(1)) begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (evt_time_stream_dst.valid && evt_time_stream_src.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Track the epoch of every time event that actually leaves, enabled or not.
    src_fire = evt_time_stream_src.valid && evt_time_stream_src.ready && (state_q != INSERT);
    if (src_fire && is_time) begin
      last_epoch_d = epoch;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_epoch_q <= '0;
      ins_cnt_q    <= '0;
      count_q      <= '0;
      shift_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_epoch_q <= last_epoch_d;
      ins_cnt_q    <= ins_cnt_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
    end
  end

  assign refresh_count_o = count_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_evt_refresh_scheduler.sv
// Directed vector table plus hand-written ready-toggling and mid-burst reset sequences.
module tb_evt_refresh_scheduler;

  localparam logic [31:0] T050 = 32'h2000_0050;
  localparam logic [31:0] T100 = 32'h2000_0100;
  localparam logic [31:0] T180 = 32'h2000_0180;
  localparam logic [31:0] T200 = 32'h2000_0200;
  localparam logic [31:0] T250 = 32'h2000_0250;
  localparam logic [31:0] T300 = 32'h2000_0300;
  localparam logic [31:0] T700 = 32'h2000_0700;
  localparam logic [31:0] T900 = 32'h2000_0900;
  localparam logic [31:0] SPK  = 32'h1000_00AB;
  localparam logic [31:0] UPD  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [4:0]  shift;
  logic [15:0] cnt;
  logic        busy;

  always #5 clk = ~clk;

  SNE_EVENT_STREAM dst_if ();
  SNE_EVENT_STREAM src_if ();

  evt_refresh_scheduler dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .enable_i            (en),
    .refresh_shift_i     (shift),
    .evt_time_stream_dst (dst_if),
    .evt_time_stream_src (src_if),
    .refresh_count_o     (cnt),
    .busy_o              (busy)
  );

  typedef struct {
    logic        rn, en, dv;
    logic [31:0] devt;
    logic        sr;
    logic        sv;
    logic [31:0] sevt;
    logic        dr, bz;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [22];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rn, logic e, logic dv, logic [31:0] de, logic sr,
                              logic sv, logic [31:0] se, logic dr, logic bz, logic [15:0] c);
    vec_t r;
    r.rn = rn; r.en = e; r.dv = dv; r.devt = de; r.sr = sr;
    r.sv = sv; r.sevt = se; r.dr = dr; r.bz = bz; r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input int ctx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", name, ctx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; shift = 5'd8;
    dst_if.valid = 1'b0; dst_if.evt = '0; src_if.ready = 1'b1;
    tick(); tick();

    //           rn en dv devt  sr | sv sevt  dr bz cnt
    vecs[0]  = mk(0, 1, 0, 0,    1,  0, 0,    1, 0, 0);
    vecs[1]  = mk(1, 1, 1, T100, 1,  0, 0,    0, 0, 0);
    vecs[2]  = mk(1, 1, 1, T100, 1,  1, UPD,  0, 1, 0);
    vecs[3]  = mk(1, 1, 1, T100, 1,  1, T100, 1, 1, 1);
    vecs[4]  = mk(1, 1, 1, T180, 1,  1, T180, 1, 0, 1);
    vecs[5]  = mk(1, 1, 1, SPK,  1,  1, SPK,  1, 0, 1);
    vecs[6]  = mk(1, 1, 1, T180, 0,  1, T180, 0, 0, 1);
    vecs[7]  = mk(1, 1, 1, T900, 1,  0, 0,    0, 0, 1);
    vecs[8]  = mk(1, 1, 1, T900, 1,  1, UPD,  0, 1, 1);
    vecs[9]  = mk(1, 1, 1, T900, 1,  1, UPD,  0, 1, 2);
    vecs[10] = mk(1, 1, 1, T900, 1,  1, UPD,  0, 1, 3);
    vecs[11] = mk(1, 1, 1, T900, 1,  1, UPD,  0, 1, 4);
    vecs[12] = mk(1, 1, 1, T900, 1,  1, T900, 1, 1, 5);
    vecs[13] = mk(1, 1, 0, T900, 1,  0, 0,    1, 0, 5);
    vecs[14] = mk(1, 0, 1, T200, 1,  1, T200, 1, 0, 5);
    vecs[15] = mk(1, 1, 1, T250, 1,  1, T250, 1, 0, 5);
    vecs[16] = mk(1, 1, 1, UPD,  1,  1, UPD,  1, 0, 5);
    vecs[17] = mk(1, 1, 1, T100, 1,  0, 0,    0, 0, 5);
    vecs[18] = mk(1, 1, 1, T100, 1,  1, UPD,  0, 1, 5);
    vecs[19] = mk(1, 1, 1, T100, 1,  1, T100, 1, 1, 6);
    vecs[20] = mk(1, 1, 0, T100, 1,  0, 0,    1, 0, 6);
    vecs[21] = mk(1, 1, 1, T050, 1,  1, T050, 1, 0, 6);

    for (int i = 0; i < 22; i++) begin
      rst_n = vecs[i].rn; en = vecs[i].en;
      dst_if.valid = vecs[i].dv; dst_if.evt = vecs[i].devt; src_if.ready = vecs[i].sr;
      #1;
      chk("src_valid", i, 32'(src_if.valid), 32'(vecs[i].sv));
      if (vecs[i].sv) chk("src_evt", i, src_if.evt, vecs[i].sevt);
      chk("dst_ready", i, 32'(dst_if.ready), 32'(vecs[i].dr));
      chk("busy", i, 32'(busy), 32'(vecs[i].bz));
      chk("count", i, 32'(cnt), 32'(vecs[i].cnt));
      tick();
    end

    // Three-update burst (epoch 0 -> 3) with a randomly stalling sink.
    begin
      int  upd;
      bit  done;
      logic sr;
      en = 1'b1; dst_if.valid = 1'b1; dst_if.evt = T300; src_if.ready = 1'b1;
      #1;
      chk("burst_trig_valid", 100, 32'(src_if.valid), 32'd0);
      chk("burst_trig_ready", 100, 32'(dst_if.ready), 32'd0);
      tick();
      upd = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        sr = 1'($urandom_range(0, 1));
        src_if.ready = sr;
        #1;
        chk("burst_busy", 200 + c, 32'(busy), 32'd1);
        chk("burst_valid", 200 + c, 32'(src_if.valid), 32'd1);
        if (upd < 3) begin
          chk("burst_evt", 200 + c, src_if.evt, UPD);
          chk("burst_dready", 200 + c, 32'(dst_if.ready), 32'd0);
        end else begin
          chk("burst_evt", 200 + c, src_if.evt, T300);
          chk("burst_dready", 200 + c, 32'(dst_if.ready), 32'(sr));
        end
        tick();
        if (sr) begin
          if (upd < 3) upd++;
          else done = 1'b1;
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL burst_timeout: got %0d updates, held event not released", upd);
      end
      dst_if.valid = 1'b0; src_if.ready = 1'b1;
      #1;
      chk("burst_end_busy", 300, 32'(busy), 32'd0);
      chk("burst_end_count", 300, 32'(cnt), 32'd9);
      tick();
    end

    // Reset mid-burst (epoch 3 -> 7, four updates) with two updates outstanding.
    dst_if.valid = 1'b1; dst_if.evt = T700; src_if.ready = 1'b1;
    #1;
    chk("rst_trig_valid", 400, 32'(src_if.valid), 32'd0);
    tick();
    tick();
    tick();
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk("rst_pre_evt", 401, src_if.evt, UPD);
    chk("rst_pre_busy", 401, 32'(busy), 32'd1);
    chk("rst_pre_count", 401, 32'(cnt), 32'd11);
    tick();
    chk("rst_busy", 402, 32'(busy), 32'd0);
    chk("rst_count", 402, 32'(cnt), 32'd0);
    chk("rst_valid", 402, 32'(src_if.valid), 32'd1);
    chk("rst_evt", 402, src_if.evt, T700);
    chk("rst_dready", 402, 32'(dst_if.ready), 32'd1);
    rst_n = 1'b1;
    tick();
    dst_if.valid = 1'b0;
    #1;
    chk("post_rst_busy", 403, 32'(busy), 32'd0);
    chk("post_rst_count", 403, 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/evt_refresh_scheduler.md
EVT_REFRESH_SCHEDULER -- requirements
Module: evt_refresh_scheduler

Interface
REQ-001 SHALL have parameter TS_WIDTH, default 28, timestamp value width (bits [TS_WIDTH-1:0] of timestamp.value).
REQ-002 SHALL have parameter MAX_CATCHUP, default 4, maximum number of update events inserted per crossing (range 1..15).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of refresh_count_o.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable_i  input  1  enables update insertion; when low the block is a pure pass-through.
REQ-007 SHALL have port refresh_shift_i  input  $clog2(TS_WIDTH)  refresh period exponent; period = 2^refresh_shift_i; legal range 1..TS_WIDTH-1.
REQ-008 SHALL have port evt_time_stream_dst  SNE_EVENT_STREAM.dst  --  incoming event stream.
REQ-009 SHALL have port evt_time_stream_src  SNE_EVENT_STREAM.src  --  outgoing event stream.
REQ-010 SHALL have port refresh_count_o  output  CNT_WIDTH  total update events inserted since reset, saturating at all-ones.
REQ-011 SHALL have port busy_o  output  1  high while in INSERT or RELEASE.

Function
REQ-012 SHALL define states IDLE, INSERT, RELEASE.
REQ-013 In IDLE, SHALL connect dst to src combinationally (valid, evt, ready), zero latency.
REQ-014 SHALL compute epoch = timestamp.value >> refresh_shift_i for valid EVT_TIME events on dst.
REQ-015 SHALL hold last_epoch_q (TS_WIDTH bits), updated with the epoch of each EVT_TIME event on its src handshake, in every state and regardless of enable_i.
REQ-016 Trigger: IDLE & enable_i & dst.valid & EVT_TIME & epoch != last_epoch_q & epoch != 0.
REQ-017 On the trigger cycle SHALL drive src.valid=0 and dst.ready=0, load ins_cnt_q, and go to INSERT next cycle.
REQ-018 ins_cnt_q SHALL load min(epoch - last_epoch_q, MAX_CATCHUP) if epoch > last_epoch_q, else 1 (timestamp wrap counts as one crossing).
REQ-019 In INSERT SHALL drive src.valid=1, src.evt={EVT_UPDATE, zeros}, dst.ready=0; on each src.ready, decrement ins_cnt_q and increment refresh_count_o.
REQ-020 SHALL leave INSERT for RELEASE on the handshake that brings ins_cnt_q from 1 to 0.
REQ-021 In RELEASE SHALL pass the held time event dst->src; on src handshake return to IDLE and update last_epoch_q.
REQ-022 SHALL never drop, duplicate or reorder dst events; dst evt is held stable upstream while dst.ready=0.
REQ-023 SHALL sample enable_i and refresh_shift_i only in IDLE; a started burst completes even if enable_i falls.
REQ-024 Non-time events (EVT_SPIKE, EVT_UPDATE) SHALL pass through in IDLE and never trigger.
REQ-025 SHALL not retrigger on the RELEASE time event (its epoch equals the epoch just used).
REQ-026 refresh_shift_i changes SHALL be legal only while enable_i=0; behaviour otherwise is unspecified.

Reset
REQ-027 On rst_ni=0 at a clock edge: state=IDLE, last_epoch_q=0, ins_cnt_q=0, refresh_count_o=0, busy_o=0.
REQ-028 Reset mid-burst SHALL abandon remaining updates; held dst event is then forwarded by IDLE pass-through.

Structure
REQ-029 State enum and update-event constant SHALL live in sne_evt_stream_pkg alongside EVT_UPDATE, EVENT_WIDTH, OP_WIDTH.
REQ-030 Stream handshake SHALL use the existing event-stream assign/pause macros.
REQ-031 One sub-module, evt_epoch_delta (epoch extraction, compare, saturating delta), is natural; FSM and counters stay in the top.

Verification
REQ-032 shift=8, enable=1, time 0x100 after reset -> one UPDATE, then TIME 0x100; refresh_count_o=1.
REQ-033 shift=8, last TIME 0x100, next TIME 0x900 (delta 8) -> exactly 4 UPDATEs (MAX_CATCHUP) then TIME 0x900; count +4.
REQ-034 TIME 0x180 after 0x100 (same epoch) and SPIKE events -> pure pass-through, no UPDATE, same-cycle forwarding.
REQ-035 src.ready toggling 0/1 randomly during a 3-update burst -> 3 UPDATEs, then held TIME, no loss; busy_o high throughout.
REQ-036 enable=0 with TIME 0x200, then enable=1 with TIME 0x250 -> no UPDATE (epoch tracked while disabled).
REQ-037 rst_ni low during INSERT with 2 updates left -> all state zero next cycle; held TIME forwarded unmodified.
